p2n_tx: RTL and testbench

- Response-direction NOC transmitter. Collects completed responses from the 4 perm_pkg units and serializes each as one byte-stream packet onto noc_from_dev_ctl/noc_from_dev_data.
- Uses the same framing the NOC-to-perm command receiver decodes, so it sits between the perm units and interface f.
- Round-robin arbitration across sources; one packet in flight at a time; no NOC backpressure.

---
 rtl/noc_pkg.sv | 51 +++++
 rtl/rr_arb.sv | 34 +++
 rtl/p2n_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_p2n_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the perm-to-NOC response transmitter (p2n_tx).
// Holds the FSM state encodings, the CMD byte field layout, the idle data
// value, response opcodes and small helpers to build a CMD byte and to
// decode the power-of-two length codes.
// Optional feature macro: P2N_CSUM_EN (adds the CSUM state encoding).
// ---------------------------------------------------------------------------
package noc_pkg;

  // FSM encodings. Each state names the byte that is currently on the wire.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_DEST = 3'd2;
  localparam logic [2:0] ST_ADDR = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
`ifdef P2N_CSUM_EN
  localparam logic [2:0] ST_CSUM = 3'd5;
`endif

  // CMD byte layout: {alen[1:0], dlen[2:0], op[2:0]}
  localparam int ALEN_MSB = 7;
  localparam int DLEN_MSB = 5;
  localparam int OP_MSB   = 2;

  localparam logic [7:0] NOC_IDLE_DATA = 8'h00;

  // Response opcodes produced by the perm units
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_RD_RSP   = 3'd1;
  localparam logic [2:0] OP_WR_ACK   = 3'd2;
  localparam logic [2:0] OP_PERM_RSP = 3'd3;
  localparam logic [2:0] OP_ERR_RSP  = 3'd7;

  // Length codes are log2 of the byte count; 7 gives 128, which still fits.
  function automatic logic [7:0] len_from_code(input logic [2:0] code);
    return 8'd1 << code;
  endfunction

  function automatic logic [7:0] make_cmd(input logic [1:0] alen,
                                          input logic [2:0] dlen,
                                          input logic [2:0] op);
    logic [7:0] cmd;
    cmd = '0;
    cmd[ALEN_MSB -: 2] = alen;
    cmd[DLEN_MSB -: 3] = dlen;
    cmd[OP_MSB   -: 3] = op;
    return cmd;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin arbiter core. Grants the first requester at or
// after ptr, wrapping modulo NSRC. The pointer register lives in the parent.
// Ports:
//   req  [NSRC-1:0]  request vector
//   ptr  [PW-1:0]    highest-priority index for this arbitration
//   en               arbitration allowed this cycle; gnt is zero otherwise
//   gnt  [NSRC-1:0]  one-hot grant
// ---------------------------------------------------------------------------
module rr_arb #(
  parameter int NSRC = 4,
  parameter int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NSRC-1:0] gnt
);

  // Walk offsets from farthest to nearest so the requester closest to ptr
  // is the last (winning) assignment.
  always_comb begin
    gnt = '0;
    if (en) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (|(req & (NSRC'(1) << ((int'(ptr) + i) % NSRC)))) begin
          gnt = NSRC'(1) << ((int'(ptr) + i) % NSRC);
        end
      end
    end
  end

endmodule

// File: rtl/p2n_tx.sv
// ---------------------------------------------------------------------------
// p2n_tx
// Response-direction NOC transmitter. Arbitrates round-robin between NSRC
// perm units and serializes one response at a time as a byte-stream packet:
//   CMD (ctl=1), DEST, Alen ADDR bytes (LSB first), Dlen DATA bytes (ctl=0),
//   then ctl=1 / data=0 for at least IDLE_MIN cycles.
// Optional feature macro: P2N_CSUM_EN -- appends one XOR checksum byte
// (CMD ^ DEST ^ ADDR ^ DATA) with ctl=0 after the last DATA byte.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req      [NSRC]          source has a complete response
//   gnt      [NSRC]          one-hot, header latched in this cycle
//   hdr_op/alen/dlen/dest/addr  per-source header fields
//   pld_rd   [NSRC]          one-hot payload pop to the granted source
//   pld_data [NSRC*8]        show-ahead payload bytes
//   noc_from_dev_ctl/data    registered NOC outputs
//   busy                     packet in progress
// ---------------------------------------------------------------------------
module p2n_tx
  import noc_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int IDLE_MIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   req,
  output logic [NSRC-1:0]   gnt,
  input  logic [NSRC*3-1:0] hdr_op,
  input  logic [NSRC*2-1:0] hdr_alen,
  input  logic [NSRC*3-1:0] hdr_dlen,
  input  logic [NSRC*8-1:0] hdr_dest,
  input  logic [NSRC*64-1:0] hdr_addr,
  output logic [NSRC-1:0]   pld_rd,
  input  logic [NSRC*8-1:0] pld_data,
  output logic              noc_from_dev_ctl,
  output logic [7:0]        noc_from_dev_data,
  output logic              busy
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [2:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   src_q;
  logic [3:0]      idle_cnt;
  logic [7:0]      cnt;
  logic [1:0]      alen_q;
  logic [2:0]      dlen_q;
  logic [7:0]      dest_q;
  logic [63:0]     addr_sr;
  logic            ctl_q;
  logic [7:0]      data_q;
`ifdef P2N_CSUM_EN
  logic [7:0]      csum_q;
`endif

  logic            arb_en;
  logic [NSRC-1:0] arb_gnt;
  logic [PW-1:0]   sel_idx;
  logic [2:0]      sel_op;
  logic [1:0]      sel_alen;
  logic [2:0]      sel_dlen;
  logic [7:0]      sel_dest;
  logic [63:0]     sel_addr;
  logic [PW-1:0]   next_ptr;
  logic            pop;
  logic [7:0]      pld_byte;

  assign arb_en = (state == ST_IDLE) && (idle_cnt == 4'd0);

  rr_arb #(.NSRC(NSRC), .PW(PW)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (arb_gnt)
  );

  assign gnt = arb_gnt;

  // Header mux for the source being granted this cycle
  always_comb begin
    sel_idx  = '0;
    sel_op   = '0;
    sel_alen = '0;
    sel_dlen = '0;
    sel_dest = '0;
    sel_addr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (arb_gnt[i]) begin
        sel_idx  = PW'(i);
        sel_op   = hdr_op[i*3 +: 3];
        sel_alen = hdr_alen[i*2 +: 2];
        sel_dlen = hdr_dlen[i*3 +: 3];
        sel_dest = hdr_dest[i*8 +: 8];
        sel_addr = hdr_addr[i*64 +: 64];
      end
    end
  end

  assign next_ptr = (sel_idx == PW'(NSRC - 1)) ? '0 : sel_idx + PW'(1);

  // The first payload byte is popped while the last ADDR byte is on the
  // wire so that it is registered out the following cycle; each further
  // DATA cycle pops the next one until the count runs out.
  assign pop = ((state == ST_ADDR) && (cnt == 8'd0)) ||
               ((state == ST_DATA) && (cnt != 8'd0));

  always_comb begin
    pld_byte = '0;
    pld_rd   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_q == PW'(i)) begin
        pld_byte  = pld_data[i*8 +: 8];
        pld_rd[i] = pop;
      end
    end
  end

  assign noc_from_dev_ctl  = ctl_q;
  assign noc_from_dev_data = data_q;
  assign busy              = (state != ST_IDLE);

  // Main FSM and output registers. The idle counter is reloaded with
  // IDLE_MIN-1 because the first idle byte is already on the wire when the
  // reload happens; the grant lands in the last idle cycle so the CMD byte
  // follows exactly IDLE_MIN idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      src_q    <= '0;
      idle_cnt <= 4'(IDLE_MIN);
      cnt      <= '0;
      alen_q   <= '0;
      dlen_q   <= '0;
      dest_q   <= '0;
      addr_sr  <= '0;
      ctl_q    <= 1'b1;
      data_q   <= NOC_IDLE_DATA;
`ifdef P2N_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (idle_cnt != 4'd0) begin
            idle_cnt <= idle_cnt - 4'd1;
          end else if (|arb_gnt) begin
            rr_ptr  <= next_ptr;
            src_q   <= sel_idx;
            alen_q  <= sel_alen;
            dlen_q  <= sel_dlen;
            dest_q  <= sel_dest;
            addr_sr <= sel_addr;
            ctl_q   <= 1'b1;
            data_q  <= make_cmd(sel_alen, sel_dlen, sel_op);
`ifdef P2N_CSUM_EN
            csum_q  <= make_cmd(sel_alen, sel_dlen, sel_op);
`endif
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          ctl_q  <= 1'b0;
          data_q <= dest_q;
`ifdef P2N_CSUM_EN
          csum_q <= csum_q ^ dest_q;
`endif
          state  <= ST_DEST;
        end
        ST_DEST: begin
          data_q  <= addr_sr[7:0];
          addr_sr <= addr_sr >> 8;
          cnt     <= len_from_code({1'b0, alen_q}) - 8'd1;
`ifdef P2N_CSUM_EN
          csum_q  <= csum_q ^ addr_sr[7:0];
`endif
          state   <= ST_ADDR;
        end
        ST_ADDR: begin
          if (cnt == 8'd0) begin
            data_q <= pld_byte;
            cnt    <= len_from_code(dlen_q) - 8'd1;
`ifdef P2N_CSUM_EN
            csum_q <= csum_q ^ pld_byte;
`endif
            state  <= ST_DATA;
          end else begin
            data_q  <= addr_sr[7:0];
            addr_sr <= addr_sr >> 8;
            cnt     <= cnt - 8'd1;
`ifdef P2N_CSUM_EN
            csum_q  <= csum_q ^ addr_sr[7:0];
`endif
          end
        end
        ST_DATA: begin
          if (cnt != 8'd0) begin
            data_q <= pld_byte;
            cnt    <= cnt - 8'd1;
`ifdef P2N_CSUM_EN
            csum_q <= csum_q ^ pld_byte;
`endif
          end else begin
`ifdef P2N_CSUM_EN
            data_q   <= csum_q;
            state    <= ST_CSUM;
`else
            ctl_q    <= 1'b1;
            data_q   <= NOC_IDLE_DATA;
            idle_cnt <= 4'(IDLE_MIN - 1);
            state    <= ST_IDLE;
`endif
          end
        end
`ifdef P2N_CSUM_EN
        ST_CSUM: begin
          ctl_q    <= 1'b1;
          data_q   <= NOC_IDLE_DATA;
          idle_cnt <= 4'(IDLE_MIN - 1);
          state    <= ST_IDLE;
        end
`endif
        default: begin
          ctl_q  <= 1'b1;
          data_q <= NOC_IDLE_DATA;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2n_tx.sv
// ---------------------------------------------------------------------------
// tb_p2n_tx
// Directed self-checking bench for p2n_tx (NSRC=4, IDLE_MIN=3).
// Sources are modelled as show-ahead byte streams: source s returns
// base_byte[s] + n for its n-th popped byte.
// Honours P2N_CSUM_EN by expecting the trailing checksum byte.
// ---------------------------------------------------------------------------
module tb_p2n_tx;

  localparam int NSRC     = 4;
  localparam int IDLE_MIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic [11:0]   hdr_op;
  logic [7:0]    hdr_alen;
  logic [11:0]   hdr_dlen;
  logic [31:0]   hdr_dest;
  logic [255:0]  hdr_addr;
  logic [3:0]    pld_rd;
  logic [31:0]   pld_data;
  logic          ctl;
  logic [7:0]    data;
  logic          busy;

  int total_count = 0;
  int bad_count   = 0;

  int rd_ptr [4] = '{0, 0, 0, 0};
  int rd_total   = 0;
  int pkt_start  = 0;
  int rd_start   = 0;
  int waits;

  logic [7:0] base_byte [4] = '{8'hC3, 8'h10, 8'h40, 8'h80};

  p2n_tx #(.NSRC(NSRC), .IDLE_MIN(IDLE_MIN)) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .gnt               (gnt),
    .hdr_op            (hdr_op),
    .hdr_alen          (hdr_alen),
    .hdr_dlen          (hdr_dlen),
    .hdr_dest          (hdr_dest),
    .hdr_addr          (hdr_addr),
    .pld_rd            (pld_rd),
    .pld_data          (pld_data),
    .noc_from_dev_ctl  (ctl),
    .noc_from_dev_data (data),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Source payload model: each pop advances that source's stream
  always @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (pld_rd[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
    rd_total <= rd_total + $countones(pld_rd);
  end

  always_comb begin
    pld_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      pld_data[i*8 +: 8] = base_byte[i] + 8'(rd_ptr[i]);
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total_count++;
    if (obs !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int src, input logic [2:0] op,
                               input logic [1:0] alen, input logic [2:0] dlen,
                               input logic [7:0] dest, input logic [63:0] addr,
                               input logic r);
    hdr_op[src*3 +: 3]    = op;
    hdr_alen[src*2 +: 2]  = alen;
    hdr_dlen[src*3 +: 3]  = dlen;
    hdr_dest[src*8 +: 8]  = dest;
    hdr_addr[src*64 +: 64] = addr;
    req[src]              = r;
  endtask

  // Waits (bounded) for a grant, checks it targets src and snapshots the
  // payload model so the packet check knows which bytes to expect.
  task automatic waitGrant(input int src, input bit drop, output int n_wait);
    bit got;
    got = 1'b0;
    n_wait = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      n_wait++;
      if (gnt != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checkOutput("grant_timeout", 0, 1);
    end else begin
      checkOutput("gnt_onehot", int'(gnt), 1 << src);
      checkOutput("gnt_busy", int'(busy), 0);
      pkt_start = rd_ptr[src];
      rd_start  = rd_total;
      if (drop) begin
        @(posedge clk);
        #1 req[src] = 1'b0;
      end
    end
  endtask

  task automatic checkPacket(input int src, input logic [7:0] exp_cmd,
                             input logic [1:0] alen, input logic [2:0] dlen,
                             input logic [7:0] dest, input logic [63:0] addr,
                             input int late_src);
    int alen_b;
    int dlen_b;
    int zeros;
    int exp_zeros;
    logic [7:0] exp_b;
    logic [7:0] csum;
    alen_b = 1 << alen;
    dlen_b = 1 << dlen;
    zeros  = 0;
    csum   = exp_cmd;

    @(negedge clk);
    checkOutput("cmd_ctl", int'(ctl), 1);
    checkOutput("cmd_byte", int'(data), int'(exp_cmd));
    checkOutput("cmd_busy", int'(busy), 1);

    @(negedge clk);
    if (ctl == 1'b0) zeros++;
    checkOutput("dest_byte", int'(data), int'(dest));
    csum ^= dest;

    for (int k = 0; k < alen_b; k++) begin
      @(negedge clk);
      if (ctl == 1'b0) zeros++;
      exp_b = addr[8*k +: 8];
      checkOutput("addr_byte", int'(data), int'(exp_b));
      csum ^= exp_b;
    end

    for (int k = 0; k < dlen_b; k++) begin
      @(negedge clk);
      if (ctl == 1'b0) zeros++;
      exp_b = base_byte[src] + 8'(pkt_start + k);
      checkOutput("data_byte", int'(data), int'(exp_b));
      csum ^= exp_b;
      if (k == 1 && late_src >= 0) req[late_src] = 1'b1;
    end

    exp_zeros = 1 + alen_b + dlen_b;
`ifdef P2N_CSUM_EN
    @(negedge clk);
    if (ctl == 1'b0) zeros++;
    checkOutput("csum_byte", int'(data), int'(csum));
    exp_zeros++;
`endif
    checkOutput("ctl0_run", zeros, exp_zeros);

    @(negedge clk);
    checkOutput("idle_ctl", int'(ctl), 1);
    checkOutput("idle_data", int'(data), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("pld_rd_total", rd_total - rd_start, dlen_b);
    checkOutput("pld_rd_src", rd_ptr[src] - pkt_start, dlen_b);
  endtask

  initial begin
    rst      = 1'b0;
    req      = '0;
    hdr_op   = '0;
    hdr_alen = '0;
    hdr_dlen = '0;
    hdr_dest = '0;
    hdr_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ctl", int'(ctl), 1);
    checkOutput("rst_data", int'(data), 0);
    checkOutput("rst_gnt", int'(gnt), 0);
    checkOutput("rst_pld_rd", int'(pld_rd), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst = 1'b1;

    // Single source: op=5, alen=0, dlen=0 gives CMD 8'h05.
    // With the checksum option the trailer is 05^2A^11^C3 = 8'hFD.
    applyStimulus(0, 3'b101, 2'd0, 3'd0, 8'h2A, 64'h11, 1'b1);
    waitGrant(0, 1'b1, waits);
    checkPacket(0, 8'h05, 2'd0, 3'd0, 8'h2A, 64'h11, -1);

    // Maximum length: alen=3, dlen=7, op=2 gives CMD 8'hFA
    applyStimulus(2, 3'b010, 2'd3, 3'd7, 8'hE5, 64'h8877665544332211, 1'b1);
    waitGrant(2, 1'b1, waits);
    checkPacket(2, 8'hFA, 2'd3, 3'd7, 8'hE5, 64'h8877665544332211, -1);

    // Reset during the third payload byte of a dlen=2 packet
    applyStimulus(3, 3'b111, 2'd0, 3'd2, 8'hD1, 64'h3C, 1'b1);
    waitGrant(3, 1'b1, waits);
    repeat (6) @(negedge clk);
    checkOutput("pre_rst_data", int'(data), int'(base_byte[3] + 8'(pkt_start + 2)));
    rst = 1'b0;
    #1;
    checkOutput("abort_ctl", int'(ctl), 1);
    checkOutput("abort_data", int'(data), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_pld_rd", int'(pld_rd), 0);
    @(negedge clk);
    rst = 1'b1;
    // op=3, alen=0, dlen=1 gives CMD 8'h0B
    applyStimulus(3, 3'b011, 2'd0, 3'd1, 8'h5E, 64'hA7, 1'b1);
    waitGrant(3, 1'b1, waits);
    checkPacket(3, 8'h0B, 2'd0, 3'd1, 8'h5E, 64'hA7, -1);

    // Round-robin with all four requesting; op=src, dlen=1 gives CMD 8'h08+src
    for (int s = 0; s < NSRC; s++) begin
      applyStimulus(s, 3'(s), 2'd0, 3'd1, 8'(8'hA0 + s), 64'(8'h30 + s), 1'b1);
    end
    for (int p = 0; p < 5; p++) begin
      waitGrant(p % 4, 1'b0, waits);
      if (p > 0) checkOutput("rr_gap", waits, IDLE_MIN - 1);
      if (p == 4) begin
        @(posedge clk);
        #1 req = '0;
      end
      checkPacket(p % 4, 8'(8'h08 + (p % 4)), 2'd0, 3'd1, 8'(8'hA0 + (p % 4)),
                  64'(8'h30 + (p % 4)), -1);
    end

    // Back-to-back: source 1 raises req during source 0's DATA.
    // src0: op=6, alen=1, dlen=1 -> CMD 8'h4E; src1: op=1, alen=0, dlen=0 -> 8'h01
    applyStimulus(1, 3'b001, 2'd0, 3'd0, 8'h99, 64'h5A, 1'b0);
    applyStimulus(0, 3'b110, 2'd1, 3'd1, 8'h77, 64'hBEEF, 1'b1);
    waitGrant(0, 1'b1, waits);
    checkPacket(0, 8'h4E, 2'd1, 3'd1, 8'h77, 64'hBEEF, 1);
    waitGrant(1, 1'b1, waits);
    checkOutput("b2b_gap", waits, IDLE_MIN - 1);
    checkPacket(1, 8'h01, 2'd0, 3'd0, 8'h99, 64'h5A, -1);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
